// File: rtl/timer_apb_if_if.sv
// APB4 bus bundle between the SoC interconnect (master) and the timer front-end (slave).
interface timer_apb_if_if;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  modport master (
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );
endinterface

// File: rtl/timer_apb_if.sv
// APB4 completer front-end for the timer register block: turns APB transfers into one-cycle
// wr_en/rd_en strobes, then responds after WAIT_STATES cycles. Optional address rejection: TIMER_APB_ADDR_CHECK_EN.
module timer_apb_if #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [11:0] ADDR_MAX    = 12'h01C
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  timer_apb_if_if.slave apb,
  output logic          wr_en,
  output logic          rd_en,
  output logic [11:0]   reg_addr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_strb,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_error_flag
);

`ifdef TIMER_APB_ADDR_CHECK_EN
  localparam bit AddrCheckEn = 1'b1;
`else
  localparam bit AddrCheckEn = 1'b0;
`endif

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        reject_q, reject_d;
  logic        write_q, write_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        err_now;
  logic        done_ok;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (apb.tim_psel && !apb.tim_penable) state_d = S_SETUP;
      S_SETUP: begin
        if (!apb.tim_psel)        state_d = S_IDLE;
        else if (apb.tim_penable) state_d = S_STROBE;
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT:   if (cnt_q == 4'd1) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A master that drops psel after the strobe still gets the full internal sequence, but no response.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q;
    abort_d   = abort_q;
    reject_d  = reject_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = 32'h0;
    err_now   = err_q | reg_error_flag;
    done_ok   = !abort_q && apb.tim_psel;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_SETUP) begin
          write_d  = apb.tim_pwrite;
          addr_d   = apb.tim_paddr;
          wdata_d  = apb.tim_pwdata;
          strb_d   = apb.tim_pwrite ? apb.tim_pstrb : 4'h0;
          reject_d = AddrCheckEn &&
                     ((apb.tim_paddr > ADDR_MAX) || (apb.tim_paddr[1:0] != 2'b00));
          err_d    = 1'b0;
          abort_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (state_d == S_STROBE) begin
          wr_en_d = write_q & ~reject_q;
          rd_en_d = ~write_q & ~reject_q;
        end
      end
      S_STROBE: begin
        cnt_d   = WaitLoad;
        abort_d = abort_q | ~apb.tim_psel;
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        err_d   = err_now;
        abort_d = abort_q | ~apb.tim_psel;
        if (state_d == S_DONE) begin
          pready_d  = done_ok;
          pslverr_d = done_ok & (err_now | reject_q);
          if (done_ok && !write_q && !err_now && !reject_q) prdata_d = reg_rdata;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        abort_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q     <= 4'h0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      reject_q  <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 12'h0;
      wdata_q   <= 32'h0;
      strb_q    <= 4'h0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      reject_q  <= reject_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign wr_en           = wr_en_q;
  assign rd_en           = rd_en_q;
  assign reg_addr        = addr_q;
  assign reg_wdata       = wdata_q;
  assign reg_strb        = strb_q;
  assign apb.tim_prdata  = prdata_q;
  assign apb.tim_pready  = pready_q;
  assign apb.tim_pslverr = pslverr_q;

endmodule

// File: tb/tb_timer_apb_if.sv
// Bench for timer_apb_if: a WAIT_STATES=1 and a WAIT_STATES=4 instance, a small register model,
// and strobe/response scoreboards filled as each transfer is driven.
module tb_timer_apb_if;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  timer_apb_if_if bus1 ();
  timer_apb_if_if bus4 ();

  logic        wrEn1, rdEn1, wrEn4, rdEn4;
  logic [11:0] addr1, addr4;
  logic [31:0] wdata1, wdata4, rdata1, rdata4;
  logic [3:0]  strb1, strb4;
  logic        errFlag;
  logic [31:0] regMem [0:7];

  timer_apb_if #(.WAIT_STATES(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus1),
    .wr_en(wrEn1), .rd_en(rdEn1), .reg_addr(addr1), .reg_wdata(wdata1),
    .reg_strb(strb1), .reg_rdata(rdata1), .reg_error_flag(errFlag)
  );

  timer_apb_if #(.WAIT_STATES(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus4),
    .wr_en(wrEn4), .rd_en(rdEn4), .reg_addr(addr4), .reg_wdata(wdata4),
    .reg_strb(strb4), .reg_rdata(rdata4), .reg_error_flag(errFlag)
  );

  assign rdata1 = regMem[addr1[4:2]];
  assign rdata4 = regMem[addr4[4:2]];

  // Register model: byte-strobed write on the write strobe of the WAIT_STATES=1 instance.
  always @(posedge sys_clk) begin
    if (wrEn1) begin
      for (int b = 0; b < 4; b++)
        if (strb1[b]) regMem[addr1[4:2]][b*8 +: 8] <= wdata1[b*8 +: 8];
    end
  end

  bit          sel4;
  logic        obsWr, obsRd, obsReady, obsErr;
  logic [11:0] obsAddr;
  logic [31:0] obsWdata, obsPrdata;
  logic [3:0]  obsStrb;
  assign obsWr     = sel4 ? wrEn4 : wrEn1;
  assign obsRd     = sel4 ? rdEn4 : rdEn1;
  assign obsAddr   = sel4 ? addr4 : addr1;
  assign obsWdata  = sel4 ? wdata4 : wdata1;
  assign obsStrb   = sel4 ? strb4 : strb1;
  assign obsReady  = sel4 ? bus4.tim_pready : bus1.tim_pready;
  assign obsErr    = sel4 ? bus4.tim_pslverr : bus1.tim_pslverr;
  assign obsPrdata = sel4 ? bus4.tim_prdata : bus1.tim_prdata;

  int          passCnt;
  int          totalCnt;
  logic [48:0] strobeQ [$];
  resp_t       respQ [$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic driveBus(input bit use4, input bit psel, input bit penable, input bit write,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
    bus1.tim_psel    = psel & ~use4;
    bus4.tim_psel    = psel & use4;
    bus1.tim_penable = penable & ~use4;
    bus4.tim_penable = penable & use4;
    bus1.tim_pwrite  = write;
    bus4.tim_pwrite  = write;
    bus1.tim_paddr   = addr;
    bus4.tim_paddr   = addr;
    bus1.tim_pwdata  = wdata;
    bus4.tim_pwdata  = wdata;
    bus1.tim_pstrb   = strb;
    bus4.tim_pstrb   = strb;
  endtask

  // One APB transfer; dropCycle 0 drops psel in SETUP, k>0 drops it k edges after penable rose.
  task automatic applyStimulus(input bit use4, input bit write, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input bit expStrobe, input bit expReady,
                               input logic [31:0] expRdata, input bit expErr, input int expLat,
                               input int errCycle, input int dropCycle);
    int    cycle;
    bit    seen;
    resp_t r;
    logic [48:0] acc;
    sel4  = use4;
    cycle = 0;
    seen  = 0;
    if (expStrobe) strobeQ.push_back({write, addr, wdata, write ? strb : 4'h0});
    if (expReady) begin
      r.rdata = expRdata;
      r.err   = expErr;
      r.lat   = expLat;
      respQ.push_back(r);
    end
    @(posedge sys_clk); #1;
    driveBus(use4, 1'b1, 1'b0, write, addr, wdata, strb);
    @(posedge sys_clk); #1;
    if (dropCycle == 0) driveBus(use4, 1'b0, 1'b0, write, addr, wdata, strb);
    else                driveBus(use4, 1'b1, 1'b1, write, addr, wdata, strb);
    while (cycle < 12 && !seen) begin
      @(posedge sys_clk);
      cycle++;
      #1;
      errFlag = (cycle == errCycle);
      if (cycle == dropCycle) driveBus(use4, 1'b0, 1'b0, write, addr, wdata, strb);
      @(negedge sys_clk);
      if (obsWr || obsRd) begin
        checkOutput("strobeQueued", strobeQ.size() != 0, 1);
        if (strobeQ.size() != 0) begin
          acc = strobeQ.pop_front();
          checkOutput("strobeFields", {obsWr, obsAddr, obsWdata, obsStrb}, acc);
          checkOutput("strobeCycle", cycle, 1);
        end
      end
      if (obsReady) begin
        seen = 1;
        checkOutput("preadyQueued", respQ.size() != 0, 1);
        if (respQ.size() != 0) begin
          r = respQ.pop_front();
          checkOutput("prdata", obsPrdata, r.rdata);
          checkOutput("pslverr", obsErr, r.err);
          checkOutput("latency", cycle, r.lat);
        end
      end else begin
        checkOutput("prdataOutsideDone", obsPrdata, 0);
      end
    end
    errFlag = 1'b0;
    @(posedge sys_clk); #1;
    driveBus(use4, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    if (seen) begin
      @(negedge sys_clk);
      checkOutput("afterDone", {obsReady, obsPrdata}, 0);
    end
    checkOutput("respDrained", respQ.size(), 0);
    checkOutput("strobeDrained", strobeQ.size(), 0);
    respQ.delete();
    strobeQ.delete();
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    errFlag  = 1'b0;
    sel4     = 0;
    for (int i = 0; i < 8; i++) regMem[i] = 32'h0;
    regMem[1] = 32'hC0C0DADA;
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);

    #1 sys_rst_n = 1'b0;
    #2;
    sel4 = 0; #1;
    checkOutput("resetOutputs1", {obsWr, obsRd, obsReady, obsErr, obsStrb, obsAddr, obsPrdata}, 0);
    checkOutput("resetWdata1", obsWdata, 0);
    sel4 = 1; #1;
    checkOutput("resetOutputs4", {obsWr, obsRd, obsReady, obsErr, obsStrb, obsAddr, obsPrdata}, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // write, read back, read preloaded register
    applyStimulus(0, 1, 12'h00C, 32'h12345678, 4'hF, 1, 1, 32'h0,        0, 3, -1, -1);
    applyStimulus(0, 0, 12'h00C, 32'h0,        4'hF, 1, 1, 32'h12345678, 0, 3, -1, -1);
    applyStimulus(0, 0, 12'h004, 32'h0,        4'h0, 1, 1, 32'hC0C0DADA, 0, 3, -1, -1);

    // sticky error from reg_error_flag, then a clean write
    applyStimulus(0, 1, 12'h000, 32'h00000603, 4'hF, 1, 1, 32'h0, 1, 3, 2, -1);
    applyStimulus(0, 1, 12'h008, 32'h00000055, 4'h1, 1, 1, 32'h0, 0, 3, -1, -1);

    // four wait states
    applyStimulus(1, 0, 12'h00C, 32'h0, 4'h0, 1, 1, 32'h12345678, 0, 6, -1, -1);

    // psel dropped in SETUP, then a normal read proves the FSM is idle
    applyStimulus(0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0, 0, -1, 0);
    applyStimulus(0, 0, 12'h008, 32'h0, 4'h0, 1, 1, 32'h00000055, 0, 3, -1, -1);

    // psel dropped in WAIT: strobe issued, no response
    applyStimulus(0, 0, 12'h004, 32'h0, 4'h0, 1, 0, 32'h0, 0, 0, -1, 2);

    // reset in the WAIT state of a read
    sel4 = 0;
    @(posedge sys_clk); #1;
    driveBus(1'b0, 1'b1, 1'b0, 1'b0, 12'h00C, 32'h0, 4'h0);
    @(posedge sys_clk); #1;
    driveBus(1'b0, 1'b1, 1'b1, 1'b0, 12'h00C, 32'h0, 4'h0);
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    checkOutput("addrBeforeReset", obsAddr, 12'h00C);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("resetMidWait", {obsWr, obsRd, obsReady, obsErr, obsStrb, obsAddr, obsPrdata}, 0);
    checkOutput("resetMidWaitWdata", obsWdata, 0);
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    applyStimulus(0, 0, 12'h00C, 32'h0, 4'h0, 1, 1, 32'h12345678, 0, 3, -1, -1);

`ifdef TIMER_APB_ADDR_CHECK_EN
    applyStimulus(0, 1, 12'h020, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0, 1, 3, -1, -1);
    applyStimulus(0, 0, 12'h006, 32'h0,        4'h0, 0, 1, 32'h0, 1, 3, -1, -1);
    applyStimulus(0, 0, 12'h000, 32'h0,        4'h0, 1, 1, 32'h00000603, 0, 3, -1, -1);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/timer_apb_if.md
# timer_apb_if

APB4 completer front-end for the timer register block. Decodes APB transfers on the `tim_*` bus into single-cycle `wr_en`/`rd_en` strobes with latched address, data and byte strobes. It then inserts a fixed number of wait states and returns `tim_prdata`, `tim_pready` and `tim_pslverr` to the bus. It sits between the SoC APB interconnect and `register`, and is the initiating end of the `wr_en`/`rd_en` access interface that `register` responds to.

## Interface
- `WAIT_STATES`, default 1: wait cycles between strobe and `tim_pready`; legal range 1–15.
- `ADDR_MAX`, default 12'h01C: highest valid word address.
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `tim_psel`  in  1  APB select.
- `tim_penable`  in  1  APB enable (access phase).
- `tim_pwrite`  in  1  1 = write, 0 = read.
- `tim_paddr`  in  12  APB byte address.
- `tim_pwdata`  in  32  APB write data.
- `tim_pstrb`  in  4  APB byte strobes.
- `tim_prdata`  out  32  read data; valid only while `tim_pready`=1 on a read.
- `tim_pready`  out  1  transfer complete.
- `tim_pslverr`  out  1  transfer error; valid only with `tim_pready`.
- `wr_en`  out  1  one-cycle write strobe to `register`.
- `rd_en`  out  1  one-cycle read strobe to `register`.
- `reg_addr`  out  12  latched address.
- `reg_wdata`  out  32  latched write data.
- `reg_strb`  out  4  latched strobes; forced 0 on reads.
- `reg_rdata`  in  32  `register` read data (its `tim_prdata`).
- `reg_error_flag`  in  1  `register` illegal-write indication.

## Operation
- States:
  - IDLE: entered on reset.
  - SETUP
  - STROBE
  - WAIT: uses a 4-bit down-counter.
  - DONE
- IDLE → SETUP when `psel`=1 and `penable`=0 are sampled. Address, data, strobes and direction are latched on this edge.
- SETUP → STROBE when `psel`=1 and `penable`=1 are sampled.
  - If `psel` drops instead, abort to IDLE. No strobe, no `pready`.
- STROBE lasts one cycle.
  - `wr_en` or `rd_en` is high for that cycle only.
  - The strobe is suppressed if the address is rejected (see Configuration).
  - The counter loads `WAIT_STATES`.
  - Next state is WAIT.
- WAIT:
  - The counter decrements each cycle.
  - `reg_error_flag` is OR-ed into a sticky error bit every WAIT cycle.
  - On the last WAIT cycle, `reg_rdata` is captured into the `prdata` register.
  - Leave WAIT for DONE when the counter reaches 1.
- DONE lasts one cycle.
  - `pready`=1.
  - `pslverr` = sticky error OR address reject.
  - `prdata` = captured data for an error-free read, 0 otherwise.
  - Next state is IDLE; the sticky error bit clears.
- `psel` deasserted in STROBE or WAIT: complete the internal sequence (the strobe is already issued), but do not assert `pready`. Return to IDLE.
- A new SETUP cannot be sampled in DONE. Back-to-back transfers cost one IDLE cycle.
- Reset at any point:
  - Immediate return to IDLE.
  - All outputs 0; counter and sticky error cleared.
  - An in-flight strobe is cancelled.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Edge E0 samples SETUP. `wr_en`/`rd_en` are high between E1 and E2, so `register` captures at E2.
- With `WAIT_STATES`=N:
  - `pready` is high between edges E(2+N) and E(3+N).
  - Access-phase length is 2+N cycles; the default is 3.
- `reg_addr`, `reg_wdata` and `reg_strb` are stable from E0 until return to IDLE.
- `prdata` is nonzero only in DONE.

## Configuration
- `TIMER_APB_ADDR_CHECK_EN` defined:
  - An address above `ADDR_MAX`, or with `paddr[1:0]` ≠ 0, is rejected.
  - A rejected address gets no strobe, and the full wait sequence still runs.
  - DONE then returns `pslverr`=1 and `prdata`=0.
- Not defined:
  - Every address is forwarded.
  - `pslverr` comes only from `reg_error_flag`.

## Test plan
- Write 0x00C = 0x12345678, strb 0xF, then read 0x00C:
  - exactly one `wr_en` cycle, with `reg_addr`=0x00C and `reg_wdata`=0x12345678;
  - the read returns 0x12345678 with `pready`=1 and `pslverr`=0, 3 cycles after `penable` rises.
- Read 0x004 with `reg_rdata` driven 0xC0C0DADA:
  - `rd_en` pulses once with `reg_strb`=0;
  - `prdata`=0xC0C0DADA only in the DONE cycle.
- Write 0x000 = 0x603 while `reg_error_flag` is pulsed during WAIT → `pready`=1 with `pslverr`=1. The following clean write has `pslverr`=0 (sticky bit cleared).
- With `TIMER_APB_ADDR_CHECK_EN`:
  - write 0x020 → no `wr_en`, `pslverr`=1;
  - read 0x006 → no `rd_en`, `pslverr`=1, `prdata`=0.
- With `WAIT_STATES`=4 → `pready` rises 6 cycles after `penable`. With `psel` dropped in SETUP → no strobe, no `pready`, FSM back in IDLE.
- Assert `sys_rst_n`=0 during WAIT of a read → all outputs 0 immediately. After release, the next read of 0x00C completes normally.
